// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
// The default depth is also used where the instruction memory is declared.
package loader_pkg;

    localparam int DEPTH_WORDS_DEFAULT = 1024;
    localparam int CNT_W_DEFAULT       = 11;
    localparam int BYTES_PER_WORD      = 4;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        WRITE,
        DONE,
        ERR
    } loader_state_t;

endpackage

// File: rtl/byte_word_assembler.sv
// Collects four little-endian bytes into a 32-bit word.
// The word output is valid combinationally in the cycle the fourth byte is accepted.
module byte_word_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_complete
);

    logic [1:0]  byte_cnt;
    logic [23:0] shreg;

    // Bytes shift in from the top, so the first byte ends up in the lowest lane.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            byte_cnt <= '0;
            shreg    <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
        end else if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            shreg    <= {byte_data, shreg[23:8]};
        end
    end

    assign word          = {byte_data, shreg};
    assign word_complete = accept && (byte_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a word-count header plus program words from a byte stream into instruction memory,
// holding the core in reset until a load completes successfully.
module instr_mem_loader
    import loader_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
    parameter int CNT_W       = CNT_W_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    output logic        we_o,
    output logic [31:0] waddr_o,
    output logic [31:0] wdata_o,
    output logic        core_rst_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    loader_state_t    state, state_next;
    logic [CNT_W-1:0] n_words, word_idx, idx_inc, hdr_count;
    logic [31:0]      word;
    logic             accept, word_complete, clear;
    logic             hdr_load, write_issue, idx_advance;
    logic             hdr_bad;

    assign byte_ready_o = (state == HDR) || (state == DATA);
    assign accept       = byte_valid_i && byte_ready_o;
    assign busy_o       = (state == HDR) || (state == DATA) || (state == WRITE);
    assign done_o       = (state == DONE);
    assign err_o        = (state == ERR);
    // A restart from DONE puts the core back into reset in the cycle start_i is seen.
    assign core_rst_o   = !((state == DONE) && !start_i);

    assign hdr_count = word[CNT_W-1:0];
    assign hdr_bad   = (|word[31:CNT_W]) || (hdr_count > CNT_W'(DEPTH_WORDS));
    assign idx_inc   = word_idx + 1'b1;

    byte_word_assembler u_asm (
        .clk           (clk_i),
        .rst_n         (rst_n_i),
        .clear         (clear),
        .accept        (accept),
        .byte_data     (byte_data_i),
        .word          (word),
        .word_complete (word_complete)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_next  = state;
        clear       = 1'b0;
        hdr_load    = 1'b0;
        write_issue = 1'b0;
        idx_advance = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                if (start_i) begin
                    state_next = HDR;
                    clear      = 1'b1;
                end
            end
            HDR: begin
                if (word_complete) begin
                    hdr_load = 1'b1;
                    if (hdr_bad)               state_next = ERR;
                    else if (hdr_count == '0)  state_next = DONE;
                    else                       state_next = DATA;
                end
            end
            DATA: begin
                if (word_complete) begin
                    write_issue = 1'b1;
                    state_next  = WRITE;
                end
            end
            WRITE: begin
                idx_advance = 1'b1;
                state_next  = (idx_inc == n_words) ? DONE : DATA;
            end
            default: state_next = IDLE;
        endcase
    end

    // The write port is registered; we_o is high exactly during the WRITE state.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            n_words  <= '0;
            word_idx <= '0;
            we_o     <= 1'b0;
            waddr_o  <= '0;
            wdata_o  <= '0;
        end else begin
            we_o <= write_issue;
            if (clear) begin
                n_words  <= '0;
                word_idx <= '0;
            end else begin
                if (hdr_load)    n_words  <= hdr_count;
                if (idx_advance) word_idx <= idx_inc;
            end
            if (write_issue) begin
                waddr_o <= {{(30 - CNT_W){1'b0}}, word_idx, 2'b00};
                wdata_o <= word;
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: a reference model queues expected writes,
// a monitor pops and compares them whenever we_o is seen.
module tb_instr_mem_loader;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready, we, core_rst, busy, done, err;
    logic [31:0] waddr, wdata;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] words[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_writes = 0;
    logic [31:0] last_waddr = '0;
    bit          toggle_mode = 1'b0;

    instr_mem_loader dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .start_i      (start),
        .byte_valid_i (byte_valid),
        .byte_data_i  (byte_data),
        .byte_ready_o (byte_ready),
        .we_o         (we),
        .waddr_o      (waddr),
        .wdata_o      (wdata),
        .core_rst_o   (core_rst),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n && we) begin
            n_writes++;
            last_waddr = waddr;
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", waddr, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", waddr, e.addr);
                check("write_data", wdata, e.data);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        int budget = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 200) check("byte_ready_timeout", {31'b0, byte_ready}, 32'd1);
        @(negedge clk);
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
        if (toggle_mode) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic start_load();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("core_rst_after_start", {31'b0, core_rst}, 32'd1);
        check("busy_after_start", {31'b0, busy}, 32'd1);
        check("done_cleared", {31'b0, done}, 32'd0);
        check("err_cleared", {31'b0, err}, 32'd0);
    endtask

    task automatic wait_idle();
        int budget = 0;
        while (busy && budget < 20000) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 20000) check("idle_timeout", {31'b0, busy}, 32'd0);
    endtask

    // Reference model: a count above the memory depth (including any upper header bits)
    // is rejected, otherwise word i lands at byte address 4*i.
    task automatic run_load(input logic [31:0] hdr, input int mid_start);
        bit is_err = (hdr > 32'(DEPTH));
        if (!is_err)
            for (int i = 0; i < int'(hdr); i++) exp_q.push_back('{addr: 32'(i * 4), data: words[i]});
        start_load();
        send_word(hdr);
        if (!is_err) begin
            for (int i = 0; i < int'(hdr); i++) begin
                if (i == mid_start) start = 1'b1;
                send_word(words[i]);
                start = 1'b0;
            end
        end
        wait_idle();
        repeat (2) @(negedge clk);
        check("load_done", {31'b0, done}, {31'b0, !is_err});
        check("load_err", {31'b0, err}, {31'b0, is_err});
        check("load_core_rst", {31'b0, core_rst}, {31'b0, is_err});
        check("pending_writes", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic fill_random(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom);
    endtask

    initial begin
        int base;
        repeat (3) @(negedge clk);
        check("rst_core_rst", {31'b0, core_rst}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_we", {31'b0, we}, 32'd0);
        check("rst_ready", {31'b0, byte_ready}, 32'd0);
        check("rst_waddr", waddr, 32'd0);
        check("rst_wdata", wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Asynchronous reset after two data bytes aborts the load.
        start_load();
        send_word(32'd2);
        send_byte(8'h93);
        send_byte(8'h00);
        #2 rst_n = 1'b0;
        #1;
        check("abort_core_rst", {31'b0, core_rst}, 32'd1);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_ready", {31'b0, byte_ready}, 32'd0);
        check("abort_we", {31'b0, we}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_err", {31'b0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        byte_valid = 1'b1;
        repeat (10) @(negedge clk);
        byte_valid = 1'b0;
        check("writes_after_abort", 32'(n_writes), 32'd0);

        // Two-word program, continuous then gapped stream.
        words.delete();
        words.push_back(32'h0010_0093);
        words.push_back(32'h0020_0113);
        toggle_mode = 1'b0;
        run_load(32'd2, -1);
        toggle_mode = 1'b1;
        run_load(32'd2, -1);
        check("two_word_writes", 32'(n_writes), 32'd4);

        // Zero-length header: core released the cycle after the 4th header byte.
        toggle_mode = 1'b0;
        base = n_writes;
        start_load();
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        check("zero_hdr_core_rst_before", {31'b0, core_rst}, 32'd1);
        send_byte(8'h00);
        check("zero_hdr_core_rst_after", {31'b0, core_rst}, 32'd0);
        check("zero_hdr_done", {31'b0, done}, 32'd1);
        repeat (3) @(negedge clk);
        check("zero_hdr_writes", 32'(n_writes - base), 32'd0);

        // Oversized header, stream ignored while in ERR, then recovery.
        words.delete();
        run_load(32'h0000_0401, -1);
        byte_valid = 1'b1;
        repeat (10) @(negedge clk);
        check("err_ready", {31'b0, byte_ready}, 32'd0);
        byte_valid = 1'b0;
        fill_random(1);
        run_load(32'd1, -1);
        run_load(32'h0100_0003, -1);

        // Random short programs with random stream gaps.
        repeat (6) begin
            int n = $urandom_range(1, 8);
            toggle_mode = $urandom_range(0, 1) != 0;
            fill_random(n);
            run_load(32'(n), -1);
        end

        // Full-depth load with start_i pulsed mid-load, then restart from DONE.
        toggle_mode = 1'b0;
        fill_random(DEPTH);
        base = n_writes;
        run_load(32'(DEPTH), 500);
        check("full_write_count", 32'(n_writes - base), 32'(DEPTH));
        check("full_last_addr", last_waddr, 32'h0000_0FFC);
        fill_random(1);
        run_load(32'd1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
